// File: rtl/wb_pkg.sv
// Shared constants and writeback source tags for the register-file write arbiter.
package wb_pkg;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LOAD = 2'd2
  } wb_src_e;
endpackage

// File: rtl/load_result_fifo.sv
// Small FIFO holding late load results ({rd, data}) until they win the write port.
module load_result_fifo #(
  parameter int DEPTH = 2,
  parameter int PW    = 37
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [PW-1:0] push_data,
  input  logic          pop,
  output logic [PW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int IW   = $clog2(DEPTH);
  localparam int PTRW = IW + 1;

  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   mem [DEPTH];
  logic            do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_q[IW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTRW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[IW-1:0]] <= push_data;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Shares the register file write port between ALU writeback and buffered load
// results, and tracks outstanding loads to stall dependent issue.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH      = wb_pkg::WIDTH,
  parameter int DEPTH      = wb_pkg::DEPTH,
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [AW-1:0]    ld_rd,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             iss_valid,
  input  logic             iss_is_load,
  input  logic [AW-1:0]    iss_rs1,
  input  logic [AW-1:0]    iss_rs2,
  input  logic [AW-1:0]    iss_rd,
  output logic             stall,
  output logic             wb_hold,
  output logic             reg_we,
  output logic [AW-1:0]    reg_waddr,
  output logic [WIDTH-1:0] reg_wdata
);
  localparam int PW = AW + WIDTH;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [PW-1:0]    fifo_head;
  logic [AW-1:0]    head_rd;
  logic [WIDTH-1:0] head_data;
  logic             alu_win;

  logic             reg_we_q, reg_we_d;
  logic [AW-1:0]    reg_waddr_q, reg_waddr_d;
  logic [WIDTH-1:0] reg_wdata_q, reg_wdata_d;
  wb_src_e          src_q, src_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [DEPTH-1:0] pend_q, pend_d;

  load_result_fifo #(.DEPTH(LQ_DEPTH), .PW(PW)) u_lq (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data({ld_rd, ld_data}),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign {head_rd, head_data} = fifo_head;
  assign ld_ready  = !fifo_full;
  assign fifo_push = ld_valid && !fifo_full;
  // An ALU write to x0 is discarded, so it leaves the port free for the FIFO head.
  assign alu_win   = alu_valid && (alu_rd != '0);
  assign fifo_pop  = !alu_win && !fifo_empty;

  assign stall     = iss_valid && (pend_q[iss_rs1] || pend_q[iss_rs2] || pend_q[iss_rd]);
  assign wb_hold   = (starve_q == SW'(STARVE_MAX));
  assign reg_we    = reg_we_q;
  assign reg_waddr = reg_waddr_q;
  assign reg_wdata = reg_wdata_q;

  always_comb begin
    reg_we_d    = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_wdata_d = reg_wdata_q;
    src_d       = SRC_NONE;
    if (alu_win) begin
      reg_we_d    = 1'b1;
      reg_waddr_d = alu_rd;
      reg_wdata_d = alu_data;
      src_d       = SRC_ALU;
    end else if (fifo_pop) begin
      reg_we_d    = (head_rd != '0);
      reg_waddr_d = head_rd;
      reg_wdata_d = head_data;
      src_d       = SRC_LOAD;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_pop)
      starve_d = '0;
    else if (!fifo_empty && alu_win && (starve_q != SW'(STARVE_MAX)))
      starve_d = starve_q + SW'(1);
  end

  // Clear is applied before set so an issue to the same register on that edge wins.
  always_comb begin
    pend_d = pend_q;
    if (reg_we_q && (src_q == SRC_LOAD)) pend_d[reg_waddr_q] = 1'b0;
    if (iss_valid && iss_is_load && !stall && (iss_rd != '0)) pend_d[iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      src_q       <= SRC_NONE;
      starve_q    <= '0;
      pend_q      <= '0;
    end else begin
      reg_we_q    <= reg_we_d;
      reg_waddr_q <= reg_waddr_d;
      reg_wdata_q <= reg_wdata_d;
      src_q       <= src_d;
      starve_q    <= starve_d;
      pend_q      <= pend_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
  localparam int W    = 32;
  localparam int AW   = 5;
  localparam int LQ   = 2;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, ld_valid, ld_ready, iss_valid, iss_is_load;
  logic [AW-1:0] alu_rd, ld_rd, iss_rs1, iss_rs2, iss_rd, reg_waddr;
  logic [W-1:0]  alu_data, ld_data, reg_wdata;
  logic          stall, wb_hold, reg_we;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.WIDTH(W), .DEPTH(32), .LQ_DEPTH(LQ), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_is_load(iss_is_load),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .stall(stall), .wb_hold(wb_hold),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata)
  );

  // Protocol: once wb_hold has been seen for a cycle, the ALU must stay quiet.
  logic hold_d1 = 1'b0;
  always @(posedge clk) begin
    if (!rst && hold_d1 && alu_valid) $error("FAIL protocol: alu_valid while wb_hold held");
    hold_d1 <= rst ? 1'b0 : wb_hold;
  end

  // Reference model
  typedef struct { logic [AW-1:0] rd; logic [W-1:0] data; } ld_t;
  ld_t           m_q[$];
  bit            m_pend[32];
  int            m_starve;
  bit            e_we, e_from_load;
  logic [AW-1:0] e_waddr;
  logic [W-1:0]  e_wdata;

  function automatic bit m_stall();
    return iss_valid && (m_pend[iss_rs1] || m_pend[iss_rs2] || m_pend[iss_rd]);
  endfunction
  function automatic bit m_ready();
    return m_q.size() < LQ;
  endfunction
  function automatic bit m_hold();
    return m_starve >= SMAX;
  endfunction

  task automatic m_reset();
    m_q.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_starve = 0; e_we = 0; e_from_load = 0; e_waddr = '0; e_wdata = '0;
  endtask

  task automatic m_step();
    bit st, rdy;
    ld_t h, n;
    st  = m_stall();
    rdy = m_ready();
    if (e_we && e_from_load) m_pend[e_waddr] = 1'b0;
    if (iss_valid && iss_is_load && !st && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    if (alu_valid && alu_rd != 0) begin
      e_we = 1; e_waddr = alu_rd; e_wdata = alu_data; e_from_load = 0;
      if (m_q.size() > 0 && m_starve < SMAX) m_starve++;
    end else if (m_q.size() > 0) begin
      h = m_q.pop_front();
      e_we = (h.rd != 0); e_waddr = h.rd; e_wdata = h.data; e_from_load = 1; m_starve = 0;
    end else begin
      e_we = 0; e_from_load = 0;
    end
    if (ld_valid && rdy) begin
      n.rd = ld_rd; n.data = ld_data; m_q.push_back(n);
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0;
    iss_valid = 0; iss_is_load = 0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; m_reset();
    repeat (2) @(posedge clk);
    #1; rst = 0;
    iss_valid = 1; iss_rs1 = 5'd3; iss_rs2 = 5'd9; iss_rd = 5'd17; #1;
    tests++; if (reg_we !== 1'b0) begin fails++; $display("FAIL rst_we got %b exp 0", reg_we); end
    tests++; if (reg_waddr !== '0) begin fails++; $display("FAIL rst_waddr got %0d exp 0", reg_waddr); end
    tests++; if (reg_wdata !== '0) begin fails++; $display("FAIL rst_wdata got %h exp 0", reg_wdata); end
    tests++; if (wb_hold !== 1'b0) begin fails++; $display("FAIL rst_hold got %b exp 0", wb_hold); end
    tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", ld_ready); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b exp 0", stall); end
    tick(); idle(); tick();
    tests++; if (reg_we !== 1'b0) begin fails++; $display("FAIL idle_we got %b exp 0", reg_we); end
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; #1;
    tick(); idle();
    tests++; if (reg_we !== 1'b1 || reg_waddr !== 5'd5 || reg_wdata !== 32'hDEADBEEF)
      begin fails++; $display("FAIL alu_write got we=%b a=%0d d=%h exp we=1 a=5 d=deadbeef", reg_we, reg_waddr, reg_wdata); end
    #1; tick();
    tests++; if (reg_we !== 1'b0) begin fails++; $display("FAIL alu_write_end got %b exp 0", reg_we); end
  endtask

  task automatic test_concurrent();
    idle();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h0000_3333;
    ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h7777_0007; #1;
    tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL conc_ready got %b exp 1", ld_ready); end
    tick(); idle();
    tests++; if (reg_we !== 1'b1 || reg_waddr !== 5'd3 || reg_wdata !== 32'h0000_3333)
      begin fails++; $display("FAIL conc_alu got we=%b a=%0d d=%h exp we=1 a=3 d=00003333", reg_we, reg_waddr, reg_wdata); end
    #1; tick();
    tests++; if (reg_we !== 1'b1 || reg_waddr !== 5'd7 || reg_wdata !== 32'h7777_0007)
      begin fails++; $display("FAIL conc_load got we=%b a=%0d d=%h exp we=1 a=7 d=77770007", reg_we, reg_waddr, reg_wdata); end
    #1; tick();
    tests++; if (reg_we !== 1'b0) begin fails++; $display("FAIL conc_end got %b exp 0", reg_we); end
  endtask

  task automatic test_backpressure();
    int nready = -1, nhold = -1, pushed = 0;
    bit hold_seen = 0;
    logic [AW-1:0] order[$];
    for (int c = 0; c < 24; c++) begin
      idle();
      alu_valid = (c < 8) && !hold_seen;
      alu_rd = AW'($urandom_range(1, 10)); alu_data = $urandom;
      ld_valid = (pushed < 3); ld_rd = AW'(11 + pushed); ld_data = $urandom;
      #1;
      tests++; if (ld_ready !== m_ready()) begin fails++; $display("FAIL bp_ready c=%0d got %b exp %b", c, ld_ready, m_ready()); end
      tests++; if (wb_hold !== m_hold()) begin fails++; $display("FAIL bp_hold c=%0d got %b exp %b", c, wb_hold, m_hold()); end
      if (ld_ready === 1'b0 && nready < 0) nready = c;
      if (wb_hold === 1'b1 && nhold < 0) nhold = c;
      hold_seen = (wb_hold === 1'b1);
      if (ld_valid && ld_ready === 1'b1) pushed++;
      tick();
      tests++; if (reg_we !== e_we) begin fails++; $display("FAIL bp_we c=%0d got %b exp %b", c, reg_we, e_we); end
      if (e_we) begin
        tests++; if (reg_waddr !== e_waddr || reg_wdata !== e_wdata)
          begin fails++; $display("FAIL bp_wr c=%0d got a=%0d d=%h exp a=%0d d=%h", c, reg_waddr, reg_wdata, e_waddr, e_wdata); end
      end
      if (reg_we === 1'b1 && reg_waddr >= 11 && reg_waddr <= 13) order.push_back(reg_waddr);
    end
    idle();
    tests++; if (nready != 2) begin fails++; $display("FAIL bp_full_cycle got %0d exp 2", nready); end
    tests++; if (nhold != 5) begin fails++; $display("FAIL bp_hold_cycle got %0d exp 5", nhold); end
    tests++; if (order.size() != 3 || order[0] != 11 || order[1] != 12 || order[2] != 13)
      begin fails++; $display("FAIL bp_order got %0d entries exp 11,12,13", order.size()); end
  endtask

  task automatic test_hazard();
    int we_c = -1, un_c = -1;
    idle(); iss_valid = 1; iss_is_load = 1; iss_rd = 5'd9; iss_rs1 = 5'd1; iss_rs2 = 5'd2; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL hz_issue got %b exp 0", stall); end
    tick();
    iss_is_load = 0; iss_rs1 = 5'd9; iss_rs2 = 5'd0; iss_rd = 5'd4;
    for (int c = 0; c < 10; c++) begin
      ld_valid = (c == 2); ld_rd = 5'd9; ld_data = $urandom;
      #1;
      tests++; if (stall !== m_stall()) begin fails++; $display("FAIL hz_stall c=%0d got %b exp %b", c, stall, m_stall()); end
      if (stall === 1'b0 && un_c < 0) un_c = c;
      tick();
      if (reg_we === 1'b1 && reg_waddr === 5'd9 && we_c < 0) we_c = c + 1;
    end
    tests++; if (we_c != 4 || un_c != 5) begin fails++; $display("FAIL hz_timing got we=%0d unstall=%0d exp we=4 unstall=5", we_c, un_c); end
    idle(); iss_valid = 1; iss_is_load = 1; iss_rd = 5'd9; #1; tick();
    iss_is_load = 0; iss_rd = 5'd9; iss_rs1 = 5'd0; iss_rs2 = 5'd0; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL hz_waw got %b exp 1", stall); end
    tick();
    idle(); ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h99; #1; tick();
    idle(); repeat (3) begin #1; tick(); end
    iss_valid = 1; iss_rd = 5'd9; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL hz_clear got %b exp 0", stall); end
    idle();
  endtask

  task automatic test_x0();
    idle();
    alu_valid = 1; alu_rd = '0; alu_data = 32'h1;
    ld_valid = 1; ld_rd = '0; ld_data = 32'h2;
    iss_valid = 1; iss_is_load = 1; iss_rd = '0; #1; tick();
    iss_valid = 0; iss_is_load = 0; ld_data = 32'h3; #1; tick();
    alu_valid = 1; alu_rd = 5'd1; ld_valid = 1; ld_data = 32'h4; #1; tick();
    ld_data = 32'h5; #1; tick();
    ld_valid = 0;
    for (int c = 0; c < 6; c++) begin
      alu_rd = '0; alu_valid = (c < 3);
      #1;
      tests++; if (ld_ready !== m_ready()) begin fails++; $display("FAIL x0_ready c=%0d got %b exp %b", c, ld_ready, m_ready()); end
      tick();
      tests++; if (reg_we !== 1'b0) begin fails++; $display("FAIL x0_we c=%0d got %b exp 0", c, reg_we); end
    end
    idle(); iss_valid = 1; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL x0_pending got %b exp 0", stall); end
    tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL x0_drained got %b exp 1", ld_ready); end
    idle();
  endtask

  task automatic test_random();
    bit hold_seen = 0;
    for (int c = 0; c < 400; c++) begin
      alu_valid = !hold_seen && ($urandom_range(0, 99) < 50);
      alu_rd = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
      alu_data = $urandom;
      ld_valid = ($urandom_range(0, 99) < 40); ld_rd = AW'($urandom_range(0, 7)); ld_data = $urandom;
      iss_valid = ($urandom_range(0, 99) < 60); iss_is_load = $urandom_range(0, 1);
      iss_rs1 = AW'($urandom_range(0, 7)); iss_rs2 = AW'($urandom_range(0, 7)); iss_rd = AW'($urandom_range(0, 7));
      #1;
      tests++; if (ld_ready !== m_ready()) begin fails++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, ld_ready, m_ready()); end
      tests++; if (stall !== m_stall()) begin fails++; $display("FAIL rnd_stall c=%0d got %b exp %b", c, stall, m_stall()); end
      tests++; if (wb_hold !== m_hold()) begin fails++; $display("FAIL rnd_hold c=%0d got %b exp %b", c, wb_hold, m_hold()); end
      hold_seen = (wb_hold === 1'b1);
      tick();
      tests++; if (reg_we !== e_we) begin fails++; $display("FAIL rnd_we c=%0d got %b exp %b", c, reg_we, e_we); end
      if (e_we) begin
        tests++; if (reg_waddr !== e_waddr || reg_wdata !== e_wdata)
          begin fails++; $display("FAIL rnd_wr c=%0d got a=%0d d=%h exp a=%0d d=%h", c, reg_waddr, reg_wdata, e_waddr, e_wdata); end
      end
    end
    idle(); repeat (6) begin #1; tick(); end
  endtask

  task automatic test_reset_mid();
    idle();
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_rd = AW'(c + 1); alu_data = $urandom;
      ld_valid = (c < 2); ld_rd = AW'(20 + c); ld_data = $urandom;
      iss_valid = (c < 2); iss_is_load = 1; iss_rd = AW'(20 + c);
      #1; tick();
    end
    iss_valid = 1; iss_is_load = 0; iss_rs1 = 5'd20; iss_rs2 = 5'd21; iss_rd = 5'd0; #1;
    tests++; if (ld_ready !== 1'b0 || stall !== 1'b1) begin fails++; $display("FAIL rm_setup got ready=%b stall=%b exp 0 1", ld_ready, stall); end
    #1; rst = 1; #1;
    tests++; if (reg_we !== 1'b0) begin fails++; $display("FAIL rm_we got %b exp 0", reg_we); end
    tests++; if (ld_ready !== 1'b1) begin fails++; $display("FAIL rm_ready got %b exp 1", ld_ready); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rm_stall got %b exp 0", stall); end
    tests++; if (wb_hold !== 1'b0) begin fails++; $display("FAIL rm_hold got %b exp 0", wb_hold); end
    idle(); m_reset();
    @(posedge clk); #1; rst = 0;
    for (int c = 0; c < 5; c++) begin
      #1; tick();
      tests++; if (reg_we !== 1'b0) begin fails++; $display("FAIL rm_after c=%0d got %b exp 0", c, reg_we); end
    end
  endtask

  initial begin
    test_reset();
    test_concurrent();
    test_backpressure();
    test_hazard();
    test_x0();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout: bench did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule
